// File: rtl/btn_press_conditioner.sv
// Button press conditioner: synchronises the four raw active-low buttons,
// debounces press and release, rejects multi-button patterns and emits one
// single-cycle press code per accepted physical press.
//
// Output handshake: btn_valid is a one-cycle strobe with no ready/back-pressure.
// btn_code carries the active-low button pattern in the same cycle and is
// 4'b1111 in every other cycle. multi_err is a separate one-cycle strobe and
// is never high together with btn_valid.
module btn_press_conditioner #(
  parameter int DB_CYCLES = 1_000_000,
  localparam int CW = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_code,
  output logic       btn_valid,
  output logic       btn_held,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [3:0]    NO_BTN   = 4'b1111;

  logic [3:0]    sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          merr_q, merr_d;

  // Exactly one bit of the captured pattern is low (one button pressed).
  logic [3:0] cand_low;
  logic       cand_single;
  assign cand_low    = ~cand_q;
  assign cand_single = (cand_low != 4'd0) && ((cand_low & (cand_low - 4'd1)) == 4'd0);

  // Two-flop synchroniser; the second stage is the only value the FSM uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= NO_BTN;
      sync2_q <= NO_BTN;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // State, debounce counter, captured pattern and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= NO_BTN;
      code_q  <= NO_BTN;
      valid_q <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      merr_q  <= merr_d;
    end
  end

  // Next-state logic; strobes default to idle so they last exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = NO_BTN;
    valid_d = 1'b0;
    merr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2_q != NO_BTN) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        // A change on the final count cycle still wins: no strobe.
        if (sync2_q != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          if (cand_single) begin
            code_d  = cand_q;
            valid_d = 1'b1;
          end else begin
            merr_d  = 1'b1;
          end
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        // Pattern changes while held are ignored until a full release.
        if (sync2_q == NO_BTN) begin
          cnt_d   = '0;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (sync2_q != NO_BTN) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign btn_code  = code_q;
  assign btn_valid = valid_q;
  assign multi_err = merr_q;
  assign btn_held  = (state_q == HELD) || (state_q == REL_DB);

endmodule

// File: tb/tb_btn_press_conditioner.sv
// Directed bench for btn_press_conditioner with DB_CYCLES = 4.
// Timing reference: a raw change applied just after an edge is first sampled
// at the next edge (E0); a press strobe is visible after E6 and the held flag
// drops after E6 of a clean release.
module tb_btn_press_conditioner;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_code;
  logic       btn_valid;
  logic       btn_held;
  logic       multi_err;

  btn_press_conditioner #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_code  (btn_code),
    .btn_valid (btn_valid),
    .btn_held  (btn_held),
    .multi_err (multi_err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Per-test observation statistics
  int         cyc = 0;
  int         mark;
  int         valid_cnt, multi_cnt, first_valid, first_multi;
  int         first_held, last_held, held_fall, inv_bad;
  logic [3:0] last_code;
  logic       prev_held = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    valid_cnt   = 0;
    multi_cnt   = 0;
    first_valid = -1;
    first_multi = -1;
    first_held  = -1;
    last_held   = -1;
    held_fall   = 0;
    inv_bad     = 0;
    last_code   = 4'b1111;
  endtask

  // Advance one clock edge and sample outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (btn_valid) begin
      valid_cnt++;
      last_code = btn_code;
      if (first_valid < 0) first_valid = cyc;
    end
    if (multi_err) begin
      multi_cnt++;
      if (first_multi < 0) first_multi = cyc;
    end
    if (btn_held) begin
      if (first_held < 0) first_held = cyc;
      last_held = cyc;
    end
    if (prev_held && !btn_held) held_fall++;
    prev_held = btn_held;
    if (btn_valid !== (btn_code != 4'b1111)) inv_bad++;
    if (btn_valid && multi_err) inv_bad++;
  endtask

  task automatic drive(input logic [3:0] raw, input int n);
    btn_raw = raw;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_code"},  32'(btn_code),  32'hF);
    check_eq({tag, "_valid"}, 32'(btn_valid), 32'd0);
    check_eq({tag, "_held"},  32'(btn_held),  32'd0);
    check_eq({tag, "_merr"},  32'(multi_err), 32'd0);
  endtask

  initial begin
    // Reset
    rst     = 1'b1;
    btn_raw = 4'b1111;
    #3;
    check_idle_outputs("reset");
    tick();
    tick();
    rst = 1'b0;

    // 1: single clean press, then release
    clear_stats();
    mark = cyc;
    drive(4'b1110, 20);
    check_eq("t1_valid_cnt",   32'(valid_cnt),   32'd1);
    check_eq("t1_valid_edge",  32'(first_valid), 32'(mark + DB + 3));
    check_eq("t1_code",        32'(last_code),   32'hE);
    check_eq("t1_held_start",  32'(first_held),  32'(mark + DB + 3));
    check_eq("t1_multi_cnt",   32'(multi_cnt),   32'd0);
    mark = cyc;
    drive(4'b1111, 10);
    check_eq("t1_held_end",    32'(last_held),   32'(mark + DB + 2));
    check_eq("t1_valid_after", 32'(valid_cnt),   32'd1);
    check_eq("t1_held_falls",  32'(held_fall),   32'd1);
    check_eq("t1_inv",         32'(inv_bad),     32'd0);

    // 2: bouncing press, then stable 1101
    clear_stats();
    for (int k = 0; k < 3; k++) begin
      drive(4'b1101, 2);
      drive(4'b1111, 2);
    end
    check_eq("t2_bounce_valid", 32'(valid_cnt), 32'd0);
    check_eq("t2_bounce_held",  32'(first_held), 32'hFFFF_FFFF);
    mark = cyc;
    drive(4'b1101, 10);
    check_eq("t2_valid_cnt",  32'(valid_cnt),   32'd1);
    check_eq("t2_valid_edge", 32'(first_valid), 32'(mark + DB + 3));
    check_eq("t2_code",       32'(last_code),   32'hD);
    drive(4'b1111, 10);
    check_eq("t2_inv",        32'(inv_bad),     32'd0);

    // 3: two buttons at once are rejected
    clear_stats();
    mark = cyc;
    drive(4'b1100, 10);
    check_eq("t3_multi_cnt",  32'(multi_cnt),   32'd1);
    check_eq("t3_multi_edge", 32'(first_multi), 32'(mark + DB + 3));
    check_eq("t3_valid_cnt",  32'(valid_cnt),   32'd0);
    check_eq("t3_held",       32'(btn_held),    32'd1);
    drive(4'b1111, 10);
    check_eq("t3_released",   32'(btn_held),    32'd0);
    check_eq("t3_multi_tot",  32'(multi_cnt),   32'd1);
    check_eq("t3_inv",        32'(inv_bad),     32'd0);

    // 4: hold and add buttons, release, then a fresh press
    clear_stats();
    mark = cyc;
    drive(4'b1011, 10);
    check_eq("t4_first_edge", 32'(first_valid), 32'(mark + DB + 3));
    check_eq("t4_first_code", 32'(last_code),   32'hB);
    drive(4'b0011, 5);
    drive(4'b1011, 5);
    mark = cyc;
    drive(4'b1111, 10);
    check_eq("t4_valid_cnt",  32'(valid_cnt),   32'd1);
    check_eq("t4_multi_cnt",  32'(multi_cnt),   32'd0);
    check_eq("t4_held_end",   32'(last_held),   32'(mark + DB + 2));
    clear_stats();
    mark = cyc;
    drive(4'b0111, 10);
    check_eq("t4_new_cnt",    32'(valid_cnt),   32'd1);
    check_eq("t4_new_edge",   32'(first_valid), 32'(mark + DB + 3));
    check_eq("t4_new_code",   32'(last_code),   32'h7);
    drive(4'b1111, 10);

    // 5: release bounce returns to HELD without a second strobe
    clear_stats();
    drive(4'b1110, 10);
    drive(4'b1111, 2);
    drive(4'b1110, 1);
    mark = cyc;
    drive(4'b1111, 10);
    check_eq("t5_valid_cnt",  32'(valid_cnt),   32'd1);
    check_eq("t5_code",       32'(last_code),   32'hE);
    check_eq("t5_held_falls", 32'(held_fall),   32'd1);
    check_eq("t5_held_end",   32'(last_held),   32'(mark + DB + 2));
    check_eq("t5_inv",        32'(inv_bad),     32'd0);

    // 6a: asynchronous reset during the strobe cycle
    clear_stats();
    drive(4'b1011, DB + 3);
    check_eq("t6a_strobe_seen", 32'(btn_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t6a_async");
    btn_raw = 4'b1111;
    tick();
    tick();
    rst = 1'b0;

    // 6b: reset mid-press with the button still held afterwards
    clear_stats();
    drive(4'b0111, 4);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t6b_async");
    tick();
    tick();
    rst = 1'b0;
    clear_stats();
    mark = cyc;
    drive(4'b0111, 10);
    check_eq("t6b_valid_cnt",  32'(valid_cnt),   32'd1);
    check_eq("t6b_valid_edge", 32'(first_valid), 32'(mark + DB + 3));
    check_eq("t6b_code",       32'(last_code),   32'h7);
    drive(4'b1111, 10);
    check_eq("t6b_idle_held",  32'(btn_held),    32'd0);
    check_eq("t6b_inv",        32'(inv_bad),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
